retro_catc_multi: RTL and testbench
===================================

Name: retro_catc_multi

Overview:
- Multi-channel cycle-accurate timing controller. Generates per-channel clock-enable ticks from a single fast FPGA clock.
- Each channel uses a fractional phase accumulator, so non-integer reference ratios are exact on average.
- While a channel's Delay is asserted, its missed ticks accumulate as debt. When Delay drops, the debt is repaid at a runtime-programmable catch-up rate.
- Sits between the system clock tree and console cores (CPU, PPU, APU) that must stay lock-stepped to real time across memory stalls.

Parameters:
- Channels, 2, number of independent tick channels.
- AccWidth, 32, phase accumulator width; a channel ticks on accumulator carry.
- DebtWidth, 16, unsigned debt counter width per channel; saturating.
- DivWidth, 8, width of the catch-up divider.

Ports:
- Clk  in  1  core clock; single clock domain.
- Reset  in  1  asynchronous, active-high reset.
- ClkEn  in  1  global advance enable; when 0, all state is frozen and Tick is 0.
- Increment  in  Channels*AccWidth  per-channel phase step; tick rate = Increment/2^AccWidth of Clk (NES at 200MHz ≈ 461220904).
- CatchupDiv  in  Channels*DivWidth  per-channel catch-up tick period in Clk cycles; 0 is treated as 1.
- Delay  in  Channels  per-channel stall request.
- ClearOverflow  in  1  synchronous clear of every Overflow bit.
- Tick  out  Channels  registered per-channel clock enable to the core.
- Debt  out  Channels*DebtWidth  current debt per channel.
- Behind  out  Channels  1 when the channel's Debt != 0.
- Overflow  out  Channels  sticky flag: debt saturated while a tick was still owed.

Behaviour:
- Reset (async) forces: accumulators 0, catch-up counters 0, Debt 0, Tick 0, Overflow 0. Reset may be asserted at any time, including mid-delay or mid-catch-up. First enabled edge after release starts from that state.
- All of the following are evaluated per channel on each Clk edge with ClkEn=1.
- Accumulator update: Acc <= Acc + Increment (mod 2^AccWidth). NomTick = carry-out of that add.
- Increment=0 gives no nominal ticks. A change of Increment takes effect on the next enabled edge.
- Fast counter: FastCnt counts 0..max(CatchupDiv,1)-1 and wraps. FastTick = (FastCnt == max(CatchupDiv,1)-1). The counter runs continuously, independent of debt.
- Mode DELAY (Delay=1):
  - TickNext=0.
  - If NomTick: Debt += 1, saturating at 2^DebtWidth-1.
  - If NomTick while Debt is already saturated: Overflow <= 1.
- Mode CATCHUP (Delay=0, Debt>0): TickNext = NomTick | FastTick.
  - FastTick & !NomTick: Debt -= 1.
  - NomTick (with or without FastTick): Debt unchanged; only one tick is emitted.
- Mode NORMAL (Delay=0, Debt=0): TickNext = NomTick.
- At most one Tick per channel per cycle, always.
- Tick <= TickNext: one cycle of latency from the accumulator carry.
- Behind and Debt reflect registered state.
- ClkEn=0: Acc, FastCnt and Debt hold; Tick <= 0; Overflow holds.
- ClearOverflow has priority over setting Overflow in the same cycle.
- Channels are fully independent; nothing is shared between channels except ClkEn, ClearOverflow and reset.
- Delay asserted while in CATCHUP: repayment stops immediately and the channel returns to DELAY accrual.
- Arithmetic: Debt is unsigned and never wraps below 0 or above max. The accumulator add is AccWidth+1 bits internally.

Decomposition:
- retro_catc_pkg holds:
  - function inc_for(core_hz, ref_hz, acc_width) to compute Increment constants;
  - localparam NES_INC_200M = 461220904;
  - typedef enum {NORMAL, DELAY, CATCHUP} catc_mode_t, used for debug/assertions.
- Sub-module retro_catc_channel implements one accumulator, fast counter, debt counter and registered Tick. The top generate-loops it Channels times and slices the flattened ports.

Test Plan:
- Nominal rate: Increment[0]=2^30, Delay=0, run 400 cycles → Tick[0] exactly every 4th cycle, 100 ticks total, Debt=0, Behind=0.
- Delay/recovery: Inc=2^30, CatchupDiv=2, Delay[0]=1 for 40 cycles → Debt=10, Tick=0 throughout. Release → Tick rate rises above 1/4, Debt decreases to 0. Once Behind=0, cumulative ticks = floor(cycles/4) ±1.
- Saturation: DebtWidth=4, Delay held 100 cycles at Inc=2^30 → Debt=15, Overflow=1. Pulse ClearOverflow → Overflow=0 while Debt stays 15.
- Independence: Delay[1]=1, Delay[0]=0, identical Increment → channel 0 ticks every 4 cycles unaffected; only Debt[1] grows.
- Freeze/reset: ClkEn=0 for 10 cycles mid-catch-up → Tick=0, Debt/Acc unchanged. Async Reset mid-catch-up → Tick, Debt, Overflow = 0 without waiting for a Clk edge.

Source files
------------

// File: rtl/retro_catc_pkg.sv
// Shared types and helpers for the multi-channel catch-up timing controller.
// Includes the increment calculator used to derive channel rate constants.
package retro_catc_pkg;

    // NES master clock (21.477 MHz) expressed against a 200 MHz core clock.
    localparam int unsigned NES_INC_200M = 461220904;

    typedef enum logic [1:0] {
        NORMAL,
        DELAY,
        CATCHUP
    } catc_mode_t;

    // Phase step that makes a channel tick ref_hz times per second from core_hz.
    function automatic longint unsigned inc_for(input longint unsigned core_hz,
                                                input longint unsigned ref_hz,
                                                input int unsigned acc_width);
        return (ref_hz << acc_width) / core_hz;
    endfunction

endpackage

// File: rtl/retro_catc_channel.sv
// One tick channel: fractional phase accumulator, free-running catch-up divider,
// saturating debt counter and a registered tick output.
module retro_catc_channel
    import retro_catc_pkg::*;
#(
    parameter int ACC_WIDTH  = 32,
    parameter int DEBT_WIDTH = 16,
    parameter int DIV_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clk_en,
    input  logic [ACC_WIDTH-1:0]  increment,
    input  logic [DIV_WIDTH-1:0]  catchup_div,
    input  logic                  delay,
    input  logic                  clear_overflow,
    output logic                  tick,
    output logic [DEBT_WIDTH-1:0] debt,
    output logic                  overflow
);

    localparam logic [DIV_WIDTH-1:0]  DIV_ONE  = 1;
    localparam logic [DEBT_WIDTH-1:0] DEBT_ONE = 1;

    logic [ACC_WIDTH-1:0] acc;
    logic [ACC_WIDTH:0]   sum;
    logic                 nom_tick;
    logic [DIV_WIDTH-1:0] fast_cnt;
    logic [DIV_WIDTH-1:0] fast_last;
    logic                 fast_tick;
    logic                 debt_full;
    catc_mode_t           mode;

    always_comb begin
        sum       = {1'b0, acc} + {1'b0, increment};
        nom_tick  = sum[ACC_WIDTH];
        // A divider of 0 behaves like 1: every cycle is a catch-up slot.
        fast_last = (catchup_div == '0) ? '0 : catchup_div - DIV_ONE;
        fast_tick = (fast_cnt == fast_last);
        debt_full = &debt;
        if (delay) begin
            mode = DELAY;
        end else if (debt != '0) begin
            mode = CATCHUP;
        end else begin
            mode = NORMAL;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc      <= '0;
            fast_cnt <= '0;
            debt     <= '0;
            tick     <= 1'b0;
            overflow <= 1'b0;
        end else if (!clk_en) begin
            tick <= 1'b0;
        end else begin
            acc      <= sum[ACC_WIDTH-1:0];
            fast_cnt <= fast_tick ? '0 : fast_cnt + DIV_ONE;
            tick     <= 1'b0;
            case (mode)
                DELAY: begin
                    if (nom_tick && !debt_full) debt <= debt + DEBT_ONE;
                end
                CATCHUP: begin
                    // A nominal tick absorbs a coincident catch-up slot; only one tick goes out.
                    tick <= nom_tick | fast_tick;
                    if (fast_tick && !nom_tick) debt <= debt - DEBT_ONE;
                end
                default: begin
                    tick <= nom_tick;
                end
            endcase
            if (clear_overflow) begin
                overflow <= 1'b0;
            end else if (mode == DELAY && nom_tick && debt_full) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/retro_catc_multi.sv
// Multi-channel timing controller: replicates the tick channel and slices the
// flattened per-channel buses.
module retro_catc_multi
    import retro_catc_pkg::*;
#(
    parameter int CHANNELS   = 2,
    parameter int ACC_WIDTH  = 32,
    parameter int DEBT_WIDTH = 16,
    parameter int DIV_WIDTH  = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           clk_en,
    input  logic [CHANNELS*ACC_WIDTH-1:0]  increment,
    input  logic [CHANNELS*DIV_WIDTH-1:0]  catchup_div,
    input  logic [CHANNELS-1:0]            delay,
    input  logic                           clear_overflow,
    output logic [CHANNELS-1:0]            tick,
    output logic [CHANNELS*DEBT_WIDTH-1:0] debt,
    output logic [CHANNELS-1:0]            behind,
    output logic [CHANNELS-1:0]            overflow
);

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        retro_catc_channel #(
            .ACC_WIDTH (ACC_WIDTH),
            .DEBT_WIDTH(DEBT_WIDTH),
            .DIV_WIDTH (DIV_WIDTH)
        ) u_channel (
            .clk           (clk),
            .reset         (reset),
            .clk_en        (clk_en),
            .increment     (increment[c*ACC_WIDTH +: ACC_WIDTH]),
            .catchup_div   (catchup_div[c*DIV_WIDTH +: DIV_WIDTH]),
            .delay         (delay[c]),
            .clear_overflow(clear_overflow),
            .tick          (tick[c]),
            .debt          (debt[c*DEBT_WIDTH +: DEBT_WIDTH]),
            .overflow      (overflow[c])
        );

        assign behind[c] = |debt[c*DEBT_WIDTH +: DEBT_WIDTH];
    end

endmodule

// File: tb/tb_retro_catc_multi.sv
// Bench for retro_catc_multi: directed scenarios plus randomized traffic, all
// checked cycle by cycle against a phase/debt reference model.
module tb_retro_catc_multi;
    import retro_catc_pkg::inc_for;

    localparam int CH   = 2;
    localparam int AW   = 32;
    localparam int DW   = 4;
    localparam int VW   = 8;
    localparam int DMAX = 15;

    logic              clk = 1'b0;
    logic              reset;
    logic              clk_en;
    logic              clear_overflow;
    logic [CH*AW-1:0]  increment;
    logic [CH*VW-1:0]  catchup_div;
    logic [CH-1:0]     delay;
    logic [CH-1:0]     tick;
    logic [CH*DW-1:0]  debt;
    logic [CH-1:0]     behind;
    logic [CH-1:0]     overflow;

    int checks = 0;
    int errors = 0;

    // Reference model: absolute phase, enabled-cycle count, debt as a plain integer.
    longint unsigned m_phase[CH];
    int              m_n[CH];
    int              m_debt[CH];
    bit              m_ovf[CH];
    bit              m_tick[CH];
    logic [5:0]      exp_q[$];
    int              tick_cnt[CH];
    int              cyc;

    always #5 clk = ~clk;

    retro_catc_multi #(
        .CHANNELS  (CH),
        .ACC_WIDTH (AW),
        .DEBT_WIDTH(DW),
        .DIV_WIDTH (VW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .clk_en        (clk_en),
        .increment     (increment),
        .catchup_div   (catchup_div),
        .delay         (delay),
        .clear_overflow(clear_overflow),
        .tick          (tick),
        .debt          (debt),
        .behind        (behind),
        .overflow      (overflow)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            m_phase[c]  = 0;
            m_n[c]      = 0;
            m_debt[c]   = 0;
            m_ovf[c]    = 0;
            m_tick[c]   = 0;
            tick_cnt[c] = 0;
        end
        cyc = 0;
        exp_q.delete();
    endtask

    task automatic model_edge();
        for (int c = 0; c < CH; c++) begin
            if (!clk_en) begin
                m_tick[c] = 0;
            end else begin
                longint unsigned hi0;
                int  d;
                bit  nom, fast, sat;
                d = int'(catchup_div[c*VW +: VW]);
                if (d == 0) d = 1;
                hi0 = m_phase[c] >> 32;
                m_phase[c] += longint'(increment[c*AW +: AW]);
                nom  = ((m_phase[c] >> 32) != hi0);
                fast = ((m_n[c] % d) == d - 1);
                m_n[c]++;
                sat = 0;
                if (delay[c]) begin
                    m_tick[c] = 0;
                    if (nom) begin
                        if (m_debt[c] == DMAX) sat = 1;
                        else m_debt[c]++;
                    end
                end else if (m_debt[c] > 0) begin
                    m_tick[c] = nom | fast;
                    if (fast && !nom) m_debt[c]--;
                end else begin
                    m_tick[c] = nom;
                end
                if (clear_overflow) m_ovf[c] = 0;
                else if (sat) m_ovf[c] = 1;
            end
            exp_q.push_back({m_ovf[c], m_tick[c], 4'(m_debt[c])});
        end
    endtask

    task automatic step();
        logic [5:0] e;
        @(posedge clk);
        model_edge();
        #1;
        cyc++;
        for (int c = 0; c < CH; c++) begin
            e = exp_q.pop_front();
            chk($sformatf("tick%0d", c), tick[c], e[4]);
            chk($sformatf("debt%0d", c), debt[c*DW +: DW], e[3:0]);
            chk($sformatf("ovf%0d", c), overflow[c], e[5]);
            chk($sformatf("behind%0d", c), behind[c], e[3:0] != 4'd0);
            if (tick[c]) tick_cnt[c]++;
        end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Raises reset between edges and checks that outputs clear without a clock edge.
    task automatic do_reset();
        reset = 1'b1;
        #2;
        chk("rst_tick", tick, 0);
        chk("rst_debt", debt, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_behind", behind, 0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        longint unsigned inc4;
        int last, c0, t0, diff, d_before, budget;

        inc4           = inc_for(4, 1, AW);
        reset          = 1'b0;
        clk_en         = 1'b1;
        clear_overflow = 1'b0;
        delay          = 2'b00;
        increment      = {inc4[31:0], inc4[31:0]};
        catchup_div    = {8'd3, 8'd3};
        do_reset();

        // Nominal rate on ch0 while ch1 stalls and saturates.
        delay = 2'b10;
        last  = -1;
        for (int i = 0; i < 400; i++) begin
            step();
            if (tick[0]) begin
                if (last >= 0) chk("gap0", cyc - last, 4);
                last = cyc;
            end
        end
        chk("nom_count0", tick_cnt[0], 100);
        chk("nom_debt0", debt[3:0], 0);
        chk("nom_behind0", behind[0], 0);
        chk("stall_ticks1", tick_cnt[1], 0);
        chk("sat_debt1", debt[7:4], DMAX);
        chk("sat_ovf1", overflow[1], 1);
        clear_overflow = 1'b1;
        step();
        clear_overflow = 1'b0;
        chk("clr_ovf1", overflow[1], 0);
        chk("clr_debt1", debt[7:4], DMAX);
        delay = 2'b00;
        steps(40);

        // Delay and recovery with a divide-by-2 catch-up rate.
        catchup_div = {8'd2, 8'd2};
        do_reset();
        delay = 2'b01;
        steps(40);
        chk("delay_ticks0", tick_cnt[0], 0);
        chk("delay_debt0", debt[3:0], 10);
        delay  = 2'b00;
        c0     = cyc;
        t0     = tick_cnt[0];
        budget = 0;
        while (behind[0] && budget < 200) begin
            step();
            budget++;
        end
        chk("recover_done", behind[0], 0);
        chk("catchup_rate", (tick_cnt[0] - t0) * 4 > (cyc - c0), 1);
        diff = tick_cnt[0] - cyc / 4;
        chk("cum_ticks", diff >= -1 && diff <= 1, 1);

        // Freeze mid-catch-up, then resume.
        delay = 2'b01;
        steps(20);
        delay = 2'b00;
        steps(3);
        d_before = int'(debt[3:0]);
        clk_en   = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("freeze_tick", tick, 0);
        end
        chk("freeze_debt0", debt[3:0], d_before);
        clk_en = 1'b1;
        steps(12);

        // Async reset while ch0 catches up and ch1 holds an overflow.
        delay = 2'b11;
        steps(80);
        delay = 2'b10;
        steps(3);
        chk("pre_rst_behind0", behind[0], 1);
        do_reset();
        steps(4);

        // Randomized traffic.
        catchup_div = {8'($urandom_range(0, 4)), 8'($urandom_range(0, 4))};
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 15) == 0) delay[0] = ~delay[0];
            if ($urandom_range(0, 15) == 0) delay[1] = ~delay[1];
            clk_en         = ($urandom_range(0, 9) != 0);
            clear_overflow = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 99) == 0) begin
                increment[31:0] = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom();
            end
            if ($urandom_range(0, 99) == 0) begin
                increment[63:32] = $urandom_range(0, 32'h6000_0000);
            end
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
